// File: rtl/fu_complete_arbiter.sv
// ============================================================================
// Module   : fu_complete_arbiter
// Purpose  : Round-robin arbiter that moves finished FU results onto one
//            registered result broadcast, with one holding slot per FU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fu_complete_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 6,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*XLEN-1:0]  req_result,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     cdb_valid,
   output logic [XLEN-1:0]          cdb_result,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [IDX_W-1:0]         cdb_src
);

   logic [NUM_REQ-1:0] r_slot_valid;
   logic [XLEN-1:0]    r_slot_result [NUM_REQ];
   logic [TAG_W-1:0]   r_slot_tag    [NUM_REQ];
   logic [IDX_W-1:0]   r_rr_ptr;

   logic               r_cdb_valid;
   logic [XLEN-1:0]    r_cdb_result;
   logic [TAG_W-1:0]   r_cdb_tag;
   logic [IDX_W-1:0]   r_cdb_src;

   logic [NUM_REQ-1:0] w_grant;
   logic               w_any;
   logic [IDX_W-1:0]   w_gidx;
   logic [IDX_W-1:0]   w_rr_next;

   // Scan slots starting at the round-robin pointer; first occupied slot wins.
   always_comb begin
      int               w_pos;
      logic [IDX_W-1:0] w_scan;
      w_grant = '0;
      w_any   = 1'b0;
      w_gidx  = '0;
      w_pos   = 0;
      w_scan  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_pos = int'(r_rr_ptr) + k;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         w_scan = IDX_W'(w_pos);
         if (!w_any && r_slot_valid[w_scan]) begin
            w_any           = 1'b1;
            w_gidx          = w_scan;
            w_grant[w_scan] = 1'b1;
         end
      end
   end

   assign w_rr_next = (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
         assign req_ready[i] = !flush && (!r_slot_valid[i] || w_grant[i]);

         // A granted slot may be refilled on the same edge; capture wins.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_slot_valid[i]  <= 1'b0;
               r_slot_result[i] <= '0;
               r_slot_tag[i]    <= '0;
            end else if (flush) begin
               r_slot_valid[i]  <= 1'b0;
            end else if (req_valid[i] && req_ready[i]) begin
               r_slot_valid[i]  <= 1'b1;
               r_slot_result[i] <= req_result[i*XLEN +: XLEN];
               r_slot_tag[i]    <= req_tag[i*TAG_W +: TAG_W];
            end else if (w_grant[i]) begin
               r_slot_valid[i]  <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rr_ptr     <= '0;
         r_cdb_valid  <= 1'b0;
         r_cdb_result <= '0;
         r_cdb_tag    <= '0;
         r_cdb_src    <= '0;
      end else if (flush || !w_any) begin
         r_cdb_valid  <= 1'b0;
         r_cdb_result <= '0;
         r_cdb_tag    <= '0;
         r_cdb_src    <= '0;
      end else begin
         r_rr_ptr     <= w_rr_next;
         r_cdb_valid  <= 1'b1;
         r_cdb_result <= r_slot_result[w_gidx];
         r_cdb_tag    <= r_slot_tag[w_gidx];
         r_cdb_src    <= w_gidx;
      end
   end

   assign cdb_valid  = r_cdb_valid;
   assign cdb_result = r_cdb_result;
   assign cdb_tag    = r_cdb_tag;
   assign cdb_src    = r_cdb_src;

endmodule

`default_nettype wire
